// File: rtl/xbus_decoder.sv
// Data-bus decoder between xctrl and N_SLV peripheral slots: per-slot wait states,
// a wait-timeout watchdog and a sticky trap that latches the faulting access.
module xbus_decoder #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 12,
  parameter int SEL_ADDR_W = 2,
  parameter int N_SLV      = 3,
  parameter int TIMEOUT    = 8,
  parameter int TO_W       = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    m_sel_i,
  input  logic                    m_we_i,
  input  logic [ADDR_W-1:0]       m_addr_i,
  output logic                    m_ready_o,
  output logic [DATA_W-1:0]       m_data_to_rd_o,
  output logic [N_SLV-1:0]        s_sel_o,
  input  logic [N_SLV-1:0]        s_ready_i,
  input  logic [N_SLV*DATA_W-1:0] s_data_to_rd_i,
  output logic                    trap_o,
  output logic [ADDR_W-1:0]       fault_addr_o,
  output logic                    fault_we_o,
  output logic [1:0]              fault_cause_o,
  input  logic                    trap_clr_i
);

  typedef enum logic [1:0] {IDLE, WAIT, FAULT} state_t;

  localparam logic [1:0]      CAUSE_NONE     = 2'b00;
  localparam logic [1:0]      CAUSE_UNMAPPED = 2'b01;
  localparam logic [1:0]      CAUSE_TIMEOUT  = 2'b10;
  localparam logic [TO_W-1:0] CNT_TO         = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0] CNT_MAX        = '1;
  localparam logic [TO_W-1:0] CNT_ONE        = TO_W'(1);

  state_t                state_q, state_d;
  logic [TO_W-1:0]       cnt_q, cnt_d;
  logic [SEL_ADDR_W-1:0] rd_idx_q, rd_idx_d;
  logic                  trap_q, trap_d;
  logic [ADDR_W-1:0]     fault_addr_q, fault_addr_d;
  logic                  fault_we_q, fault_we_d;
  logic [1:0]            fault_cause_q, fault_cause_d;

  logic [SEL_ADDR_W-1:0] idx;
  logic                  mapped;
  logic                  act;
  logic                  slot_rdy;
  logic                  fault_entry;
  logic [1:0]            entry_cause;

  assign idx    = m_addr_i[ADDR_W-1 -: SEL_ADDR_W];
  assign mapped = int'(idx) < N_SLV;
  assign act    = m_sel_i && (state_q != FAULT) && mapped;

  // Loop-based select keeps unmapped indices from ever addressing past N_SLV.
  always_comb begin
    s_sel_o  = '0;
    slot_rdy = 1'b0;
    for (int i = 0; i < N_SLV; i++) begin
      if (int'(idx) == i) begin
        s_sel_o[i] = act;
        slot_rdy   = s_ready_i[i];
      end
    end
  end

  assign m_ready_o = act && slot_rdy;

  always_comb begin
    m_data_to_rd_o = '0;
    for (int i = 0; i < N_SLV; i++) begin
      if (int'(rd_idx_q) == i) begin
        m_data_to_rd_o = s_data_to_rd_i[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rd_idx_d      = rd_idx_q;
    trap_d        = trap_q;
    fault_addr_d  = fault_addr_q;
    fault_we_d    = fault_we_q;
    fault_cause_d = fault_cause_q;
    fault_entry   = 1'b0;
    entry_cause   = CAUSE_NONE;

    if (act && !m_we_i && slot_rdy) begin
      rd_idx_d = idx;
    end

    unique case (state_q)
      IDLE: begin
        if (m_sel_i && !mapped) begin
          fault_entry = 1'b1;
          entry_cause = CAUSE_UNMAPPED;
        end else if (act && !slot_rdy) begin
          state_d = WAIT;
          cnt_d   = (TIMEOUT != 0) ? CNT_ONE : '0;
        end
      end
      WAIT: begin
        if (!m_sel_i || (act && slot_rdy)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_TO)) begin
          fault_entry = 1'b1;
          entry_cause = CAUSE_TIMEOUT;
        end else if ((TIMEOUT != 0) && (cnt_q != CNT_MAX)) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      FAULT: begin
        if (trap_clr_i) begin
          state_d = IDLE;
          trap_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // The whole faulting access is captured on the same edge that raises trap.
    if (fault_entry) begin
      state_d       = FAULT;
      cnt_d         = '0;
      trap_d        = 1'b1;
      fault_addr_d  = m_addr_i;
      fault_we_d    = m_we_i;
      fault_cause_d = entry_cause;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      rd_idx_q      <= '0;
      trap_q        <= 1'b0;
      fault_addr_q  <= '0;
      fault_we_q    <= 1'b0;
      fault_cause_q <= CAUSE_NONE;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rd_idx_q      <= rd_idx_d;
      trap_q        <= trap_d;
      fault_addr_q  <= fault_addr_d;
      fault_we_q    <= fault_we_d;
      fault_cause_q <= fault_cause_d;
    end
  end

  assign trap_o        = trap_q;
  assign fault_addr_o  = fault_addr_q;
  assign fault_we_o    = fault_we_q;
  assign fault_cause_o = fault_cause_q;

endmodule

// File: tb/tb_xbus_decoder.sv
// Scoreboard bench for xbus_decoder: a driver pushes the expected outcome of each
// access, a negedge monitor pops it when the DUT completes or traps.
module tb_xbus_decoder;
  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 12;
  localparam int SEL_ADDR_W = 2;
  localparam int N_SLV      = 3;
  localparam int TIMEOUT    = 8;
  localparam int TO_W       = 4;
  localparam int LO_W       = ADDR_W - SEL_ADDR_W;

  logic                    clk_i = 1'b0;
  logic                    rst_ni;
  logic                    m_sel_i;
  logic                    m_we_i;
  logic [ADDR_W-1:0]       m_addr_i;
  logic                    m_ready_o;
  logic [DATA_W-1:0]       m_data_to_rd_o;
  logic [N_SLV-1:0]        s_sel_o;
  logic [N_SLV-1:0]        s_ready_i;
  logic [N_SLV*DATA_W-1:0] s_data_to_rd_i;
  logic                    trap_o;
  logic [ADDR_W-1:0]       fault_addr_o;
  logic                    fault_we_o;
  logic [1:0]              fault_cause_o;
  logic                    trap_clr_i;

  logic [DATA_W-1:0] sd [N_SLV];

  xbus_decoder #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SEL_ADDR_W(SEL_ADDR_W),
    .N_SLV(N_SLV), .TIMEOUT(TIMEOUT), .TO_W(TO_W)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .m_sel_i(m_sel_i), .m_we_i(m_we_i),
    .m_addr_i(m_addr_i), .m_ready_o(m_ready_o), .m_data_to_rd_o(m_data_to_rd_o),
    .s_sel_o(s_sel_o), .s_ready_i(s_ready_i), .s_data_to_rd_i(s_data_to_rd_i),
    .trap_o(trap_o), .fault_addr_o(fault_addr_o), .fault_we_o(fault_we_o),
    .fault_cause_o(fault_cause_o), .trap_clr_i(trap_clr_i)
  );

  always #5 clk_i = ~clk_i;

  always_comb begin
    s_data_to_rd_i = '0;
    for (int i = 0; i < N_SLV; i++) s_data_to_rd_i[i*DATA_W +: DATA_W] = sd[i];
  end

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    bit                is_fault;
    int                slot;
    bit                we;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        cause;
    int                cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Monitor: compares each completion / trap entry against the scoreboard.
  exp_t mon_e;
  bit   rd_pend   = 1'b0;
  int   rd_slot   = 0;
  bit   trap_prev = 1'b0;
  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_ni) begin
        if (rd_pend) begin
          check("rd_data", 64'(m_data_to_rd_o), 64'(sd[rd_slot]));
          rd_pend = 1'b0;
        end
        if (m_ready_o) begin
          if (exp_q.size() == 0) check("unexpected_ready", 64'(1), 64'(0));
          else begin
            mon_e = exp_q.pop_front();
            check("ready_kind", 64'(mon_e.is_fault), 64'(0));
            check("ready_cycle", 64'(cyc), 64'(mon_e.cyc));
            check("s_sel_onehot", 64'(s_sel_o), 64'(1 << mon_e.slot));
            if (!mon_e.we) begin
              rd_pend = 1'b1;
              rd_slot = mon_e.slot;
            end
          end
        end
        if (trap_o && !trap_prev) begin
          if (exp_q.size() == 0) check("unexpected_trap", 64'(1), 64'(0));
          else begin
            mon_e = exp_q.pop_front();
            check("trap_kind", 64'(mon_e.is_fault), 64'(1));
            check("trap_cycle", 64'(cyc), 64'(mon_e.cyc));
            check("fault_addr", 64'(fault_addr_o), 64'(mon_e.addr));
            check("fault_we", 64'(fault_we_o), 64'(mon_e.we));
            check("fault_cause", 64'(fault_cause_o), 64'(mon_e.cause));
          end
        end
      end
      trap_prev = trap_o;
    end
  end

  // One master access. delay = cycles the slot holds ready low; drop_at >= 0 means
  // the master abandons the access at that cycle.
  task automatic xact(input int slot, input bit we, input int delay, input int drop_at);
    exp_t                  e;
    int                    n;
    bit                    dropped;
    logic [LO_W-1:0]       lo;
    logic [SEL_ADDR_W-1:0] sl;
    lo = LO_W'($urandom);
    sl = SEL_ADDR_W'(slot);
    for (int i = 0; i < N_SLV; i++) sd[i] = $urandom;
    e.is_fault = (slot >= N_SLV) || (delay > TIMEOUT);
    n          = (slot >= N_SLV) ? 1 : ((delay > TIMEOUT) ? TIMEOUT + 1 : delay + 1);
    e.slot     = slot;
    e.we       = we;
    e.addr     = {sl, lo};
    e.cause    = (slot >= N_SLV) ? 2'b01 : (e.is_fault ? 2'b10 : 2'b00);
    e.cyc      = cyc + (e.is_fault ? n : delay);
    dropped    = (drop_at >= 0) && (drop_at < n);
    if (!dropped) exp_q.push_back(e);
    m_sel_i  = 1'b1;
    m_we_i   = we;
    m_addr_i = e.addr;
    for (int k = 0; k < n; k++) begin
      if (k == drop_at) break;
      for (int i = 0; i < N_SLV; i++)
        s_ready_i[i] = (i == slot) ? (k == delay) : 1'($urandom_range(0, 1));
      trap_clr_i = 1'($urandom_range(0, 1));
      @(posedge clk_i); #1;
    end
    trap_clr_i = 1'b0;
    if (e.is_fault && !dropped) begin
      m_sel_i   = 1'b1;
      m_addr_i  = {{SEL_ADDR_W{1'b0}}, lo};
      s_ready_i = '1;
      #1;
      check("fault_stall_ssel", 64'(s_sel_o), 64'(0));
      check("fault_stall_ready", 64'(m_ready_o), 64'(0));
      @(posedge clk_i); #1;
      m_sel_i    = 1'b0;
      trap_clr_i = 1'b1;
      @(posedge clk_i); #1;
      trap_clr_i = 1'b0;
      check("trap_cleared", 64'(trap_o), 64'(0));
      check("fault_addr_kept", 64'(fault_addr_o), 64'(e.addr));
      check("fault_cause_kept", 64'(fault_cause_o), 64'(e.cause));
    end
    m_sel_i = 1'b0;
    m_we_i  = 1'($urandom);
    @(posedge clk_i); #1;
  endtask

  initial begin
    int slot, dly, drop;
    rst_ni     = 1'b0;
    m_sel_i    = 1'b0;
    m_we_i     = 1'b0;
    m_addr_i   = '0;
    s_ready_i  = '0;
    trap_clr_i = 1'b0;
    for (int i = 0; i < N_SLV; i++) sd[i] = $urandom;
    #12;
    check("rst_trap", 64'(trap_o), 64'(0));
    check("rst_fault_addr", 64'(fault_addr_o), 64'(0));
    check("rst_fault_we", 64'(fault_we_o), 64'(0));
    check("rst_fault_cause", 64'(fault_cause_o), 64'(0));
    check("rst_ready", 64'(m_ready_o), 64'(0));
    check("rst_ssel", 64'(s_sel_o), 64'(0));
    check("rst_rd_data", 64'(m_data_to_rd_o), 64'(sd[0]));
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    xact(1, 1'b0, 0, -1);
    xact(0, 1'b1, 3, -1);
    xact(3, 1'b0, 0, -1);
    xact(2, 1'b0, TIMEOUT + 1, -1);
    xact(2, 1'b1, TIMEOUT, -1);
    xact(1, 1'b0, 5, 2);
    xact(2, 1'b0, 12, TIMEOUT);
    xact(0, 1'b0, 1, -1);

    for (int t = 0; t < 150; t++) begin
      slot = $urandom_range(0, 3);
      dly  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 12) : $urandom_range(0, 3);
      drop = -1;
      if (dly >= 2 && $urandom_range(0, 5) == 0)
        drop = $urandom_range(1, (dly > TIMEOUT) ? TIMEOUT : dly);
      xact(slot, 1'($urandom), dly, drop);
    end

    // Fault, then asynchronous reset while trapped.
    m_sel_i  = 1'b1;
    m_we_i   = 1'b1;
    m_addr_i = 12'hC10;
    exp_q.push_back('{1'b1, 3, 1'b1, 12'hC10, 2'b01, cyc + 1});
    @(posedge clk_i); #1;
    m_sel_i = 1'b0;
    check("c10_trap", 64'(trap_o), 64'(1));
    @(negedge clk_i); #1;
    rst_ni = 1'b0;
    #1;
    check("rstf_trap", 64'(trap_o), 64'(0));
    check("rstf_fault_addr", 64'(fault_addr_o), 64'(0));
    check("rstf_fault_we", 64'(fault_we_o), 64'(0));
    check("rstf_fault_cause", 64'(fault_cause_o), 64'(0));
    #2 rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Reset mid-WAIT: the stale wait count must not survive.
    m_sel_i   = 1'b1;
    m_we_i    = 1'b0;
    m_addr_i  = 12'h812;
    s_ready_i = '0;
    repeat (5) begin @(posedge clk_i); #1; end
    rst_ni = 1'b0;
    #1;
    check("rstw_trap", 64'(trap_o), 64'(0));
    check("rstw_ready", 64'(m_ready_o), 64'(0));
    check("rstw_rd_data", 64'(m_data_to_rd_o), 64'(sd[0]));
    m_sel_i = 1'b0;
    #2 rst_ni = 1'b1;
    @(posedge clk_i); #1;
    xact(2, 1'b0, TIMEOUT, -1);

    repeat (3) begin @(posedge clk_i); #1; end
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
